// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit bridging byte-addressed CPU requests to a word-wide synchronous data memory.
// Sub-word loads/stores (read-modify-write) are built only when DM_LSU_SUBWORD_EN is defined.
module dm_lsu #(
   parameter int DM_AW = 8,
   parameter int OP_W  = 3
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OP_W-1:0] req_op,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   output logic            resp_valid,
   output logic [31:0]     resp_rdata,
   output logic            resp_err,
   output logic            dm_we,
   output logic [31:0]     dm_addr,
   output logic [31:0]     dm_din,
   input  logic [31:0]     dm_dout
);
   localparam logic [OP_W-1:0] OP_LW = 0, OP_SW = 5;
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
   state_t state, next;
   logic [DM_AW-1:0] wi_q;
   logic [31:0] d_q, ld_word, wr_word;
   logic err_q, acc, bad, err, is_st;
   assign req_ready = state == IDLE;
   assign acc = req_valid && req_ready;
   assign err = bad || |req_addr[31:DM_AW+2];
`ifdef DM_LSU_SUBWORD_EN
   localparam logic [OP_W-1:0] OP_LH = 1, OP_LHU = 2, OP_LB = 3, OP_LBU = 4, OP_SH = 6, OP_SB = 7;
   logic [OP_W-1:0] op_q;
   logic [1:0] lane_q;
   logic [31:0] rd_q, mask, rep;
   logic [15:0] half;
   logic [7:0] byt;
   assign bad = (req_op == OP_LW || req_op == OP_SW) ? |req_addr[1:0] :
                (req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) ? req_addr[0] : 1'b0;
   assign is_st = op_q >= OP_SW;
   assign half = lane_q[1] ? dm_dout[31:16] : dm_dout[15:0];
   assign byt = dm_dout[{lane_q, 3'b000} +: 8];
   assign ld_word = (op_q == OP_LH)  ? {{16{half[15]}}, half} :
                    (op_q == OP_LHU) ? {16'h0, half} :
                    (op_q == OP_LB)  ? {{24{byt[7]}}, byt} :
                    (op_q == OP_LBU) ? {24'h0, byt} : dm_dout;
   // Sub-word stores merge new lanes into the word captured in CAP
   assign mask = (op_q == OP_SB) ? 32'hFF << {lane_q, 3'b000} : 32'hFFFF << {lane_q[1], 4'b0000};
   assign rep = (op_q == OP_SB) ? {4{d_q[7:0]}} : {2{d_q[15:0]}};
   assign wr_word = (op_q == OP_SW) ? d_q : (rd_q & ~mask) | (rep & mask);
`else
   assign bad = (req_op == OP_LW || req_op == OP_SW) ? |req_addr[1:0] : 1'b1;
   assign is_st = 1'b0;
   assign ld_word = dm_dout;
   assign wr_word = d_q;
`endif
   always_comb begin
      next = state;
      case (state)
         IDLE: if (acc) next = err ? RESP : (req_op == OP_SW) ? WR : RD;
         RD: next = CAP;
         CAP: next = is_st ? WR : RESP;
         WR: next = RESP;
         default: next = IDLE;
      endcase
   end
   assign resp_valid = state == RESP;
   assign resp_err = resp_valid && err_q;
   assign dm_we = state == WR;
   assign dm_addr = (state == RD || state == CAP || state == WR) ? {{(32-DM_AW){1'b0}}, wi_q} : 32'h0;
   assign dm_din = dm_we ? wr_word : 32'h0;
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         wi_q <= '0;
         d_q <= '0;
         err_q <= 1'b0;
         resp_rdata <= '0;
`ifdef DM_LSU_SUBWORD_EN
         op_q <= '0;
         lane_q <= '0;
         rd_q <= '0;
`endif
      end else begin
         state <= next;
         if (acc) begin
            wi_q <= req_addr[DM_AW+1:2];
            d_q <= req_wdata;
            err_q <= err;
`ifdef DM_LSU_SUBWORD_EN
            op_q <= req_op;
            lane_q <= req_addr[1:0];
`endif
         end
         if (state == CAP) begin
`ifdef DM_LSU_SUBWORD_EN
            rd_q <= dm_dout;
`endif
            if (!is_st) resp_rdata <= ld_word;
         end
      end
   end
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: scoreboard bench for dm_lsu with a registered-read DM model.
module tb_dm_lsu;
   localparam logic [2:0] LW = 0, LH = 1, LHU = 2, LB = 3, LBU = 4, SW = 5, SH = 6, SB = 7;
   logic clk = 0, clr = 1, req_valid = 0;
   logic req_ready, resp_valid, resp_err, dm_we;
   logic [2:0] req_op = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [31:0] resp_rdata, dm_addr, dm_din, dm_dout;
   logic [31:0] mem [256] = '{default: 32'h0};
   int cyc = 0, nvec = 0, nmis = 0, we_cnt = 0, acc_cnt = 0;
   typedef struct {logic err; logic [31:0] rd; int lat; int t0;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   dm_lsu dut (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
   );

   always @(posedge clk) begin
      cyc++;
      if (dm_we) begin
         mem[dm_addr[7:0]] <= dm_din;
         we_cnt++;
      end
      if (dm_we || dm_addr != 0) acc_cnt++;
      dm_dout <= dm_we ? dm_din : mem[dm_addr[7:0]];
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!clr && resp_valid) begin
         exp_t e;
         if (sb.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
         end else begin
            e = sb.pop_front();
            chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            chk("resp_rdata", resp_rdata, e.rd);
            chk("latency", cyc - e.t0, e.lat);
         end
      end
   end

   task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] wd, logic e,
                        logic [31:0] rd, int lat, bit push = 1);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         nvec++;
         nmis++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1");
      end
      req_valid = 1;
      req_op = op;
      req_addr = a;
      req_wdata = wd;
      if (push) sb.push_back('{e, rd, lat, cyc});
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         nvec++;
         nmis++;
         $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] last;
      int n, we0, acc0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_flags", {29'h0, resp_valid, resp_err, dm_we}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_dm_addr", dm_addr, 32'h0);
      clr = 0;
`ifdef DM_LSU_SUBWORD_EN
      issue(SB, 32'h21, 32'h11111111, 0, 0, 0, 0);
`else
      issue(SW, 32'h20, 32'h11111111, 0, 0, 0, 0);
`endif
      n = 0;
      while (!dm_we && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("we_before_clr", {31'h0, dm_we}, 32'h1);
      clr = 1;
      #1;
      chk("clr_flags", {29'h0, resp_valid, resp_err, dm_we}, 32'h0);
      chk("clr_dm_addr", dm_addr, 32'h0);
      chk("clr_dm_din", dm_din, 32'h0);
      chk("clr_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      clr = 0;
      @(negedge clk);
      chk("clr_word8", mem[8], 32'h0);
      issue(SW, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
      issue(LW, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3);
      drain();
      chk("sw_word4", mem[4], 32'hDEADBEEF);
`ifdef DM_LSU_SUBWORD_EN
      issue(LB, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 3);
      issue(LBU, 32'h13, 32'h0, 0, 32'h000000DE, 3);
      issue(LH, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 3);
      issue(LHU, 32'h10, 32'h0, 0, 32'h0000BEEF, 3);
      issue(SB, 32'h11, 32'h12345677, 0, 32'h0000BEEF, 4);
      drain();
      chk("sb_word4", mem[4], 32'hDEAD77EF);
      issue(SH, 32'h12, 32'hAAAA5555, 0, 32'h0000BEEF, 4);
      drain();
      chk("sh_word4", mem[4], 32'h555577EF);
      issue(LW, 32'h10, 32'h0, 0, 32'h555577EF, 3);
      last = 32'h555577EF;
`else
      we0 = we_cnt;
      acc0 = acc_cnt;
      issue(LB, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1);
      issue(LH, 32'h12, 32'h0, 1, 32'hDEADBEEF, 1);
      issue(SB, 32'h11, 32'h12345677, 1, 32'hDEADBEEF, 1);
      drain();
      chk("off_word4", mem[4], 32'hDEADBEEF);
      chk("off_no_access", acc_cnt - acc0, 0);
      chk("off_no_we", we_cnt - we0, 0);
      last = 32'hDEADBEEF;
`endif
      drain();
      we0 = we_cnt;
      acc0 = acc_cnt;
      issue(LW, 32'h12, 32'h0, 1, last, 1);
      issue(SH, 32'h11, 32'h0, 1, last, 1);
      issue(LW, 32'h400, 32'h0, 1, last, 1);
      issue(SW, 32'h13, 32'h0, 1, last, 1);
      drain();
      chk("err_no_we", we_cnt - we0, 0);
      chk("err_no_access", acc_cnt - acc0, 0);
      issue(SW, 32'h3FC, 32'h0BADF00D, 0, last, 2);
      issue(LW, 32'h3FC, 32'h0, 0, 32'h0BADF00D, 3);
      drain();
      chk("top_word", mem[255], 32'h0BADF00D);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store unit that acts as the initiator to the synchronous word-wide data memory (DM).
- Accepts byte-addressed CPU load/store requests, translates them to DM word accesses, and returns responses.
- Loads: byte/halfword extraction with sign or zero extension.
- Sub-word stores: read-modify-write (read, merge, write).
- Sits between the execute stage and DM.

Parameters:
- DM_AW, 8: DM word-index width; DM depth = 2**DM_AW words.
- OP_W, 3: width of the op code.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_op  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (sub-word data taken from low bits).
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  32  load result; held until the next load response.
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or disabled op.
- dm_we  out  1  DM write enable.
- dm_addr  out  32  DM word index = {2'b00, a_q[31:2]}.
- dm_din  out  32  DM write data.
- dm_dout  in  32  DM read data. DM registers it: valid the cycle after dm_addr is presented; a write returns the new word.

Behaviour:
- **Reset (clr=1, async).** State=IDLE. resp_valid=0, resp_rdata=0, resp_err=0, internal regs=0. dm_we, dm_addr and dm_din are decoded from state, so all are 0 immediately. Reset mid-RMW aborts with no DM write.
- **Accept.** On posedge with req_valid && req_ready, capture op_q, a_q and d_q.
- **Error check at accept.** An error sends the request straight to RESP with resp_err=1 and no DM access. Errors are:
  - misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0;
  - out of range: addr[31:DM_AW+2]!=0.
- **States.** IDLE, RD, CAP, WR, RESP.
  - IDLE: req_ready=1. Error -> RESP. SW -> WR. All other ops -> RD.
  - RD: dm_we=0, dm_addr driven. DM samples at the next edge. -> CAP.
  - CAP: dm_dout valid and captured into rd_q at the edge. Loads -> RESP. SH/SB -> WR.
  - WR: dm_we=1, dm_addr driven. dm_din = d_q for SW; merged word for SH/SB. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_rdata updates only for loads without error.
- **Latency (accept edge to resp_valid cycle).**
  - Loads: 3 cycles. SW: 2. SH/SB: 4. Error: 1.
  - Back-to-back requests: the next acceptance is possible in the IDLE cycle after RESP.
- **Byte lanes.** Little-endian: byte k = bits [8k+7:8k], k = a_q[1:0]; halfword h = a_q[1] (bits [16h+15:16h]).
- **Load extension.** LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- **Merge.** SB replaces byte k of rd_q with d_q[7:0]. SH replaces halfword h with d_q[15:0]. Other bytes are preserved.
- **Outside states.** dm_addr=0 and dm_din=0 in IDLE and RESP. req_valid while req_ready=0 is ignored, not queued. The requester holds the request until it is accepted.
- **Reads.** The DM reads every cycle. The LSU uses dm_dout only in CAP.

Optional Feature:
- Macro: DM_LSU_SUBWORD_EN.
- Defined: full behaviour above.
- Undefined:
  - LH, LHU, LB, LBU, SH and SB are errors at accept (-> RESP with resp_err=1, no DM access).
  - LW/SW are unchanged.
  - CAP->WR path and merge logic are omitted.

Test Plan:
- Reset: assert clr mid-WR of SB -> dm_we drops to 0 in the same cycle; word in DM unchanged; all outputs 0.
- SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> DM word 4 written; LW resp_rdata=0xDEADBEEF, 3 cycles after accept, resp_err=0.
- Word 4=0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- Word 4=0xDEADBEEF:
  - SB 0x11, wdata=0x12345677 -> 0xDEAD77EF after 4 cycles.
  - Then SH 0x12, wdata=0xAAAA5555 -> 0x555577EF.
- Errors -> resp_err=1, 1-cycle latency, dm_we never asserted:
  - LW 0x12;
  - SH 0x11;
  - LW 0x400 with DM_AW=8.
- Macro undefined: LB 0x10 -> resp_err=1, no DM access. SW/LW round trip still passes.
